// File: rtl/dmem_responder_pkg.sv
// Shared address map and store-size encodings for the data-memory port.
// The core's pipeline stages use the same WE_* codes on Dmem_write_en.
package dmem_responder_pkg;

  localparam logic [31:0] UART_TX   = 32'h8000_0000;
  localparam logic [31:0] UART_STAT = 32'h8000_0004;
  localparam logic [31:0] MTIME_LO  = 32'h8000_0008;
  localparam logic [31:0] MTIME_HI  = 32'h8000_000C;
  localparam logic [31:0] TOHOST    = 32'h8000_0010;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  // Halves need an even address, words a 4-byte-aligned one; bytes are always fine.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == WE_HALF) && addr_lo[0]) || ((size == WE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Console TX FIFO: registered head (no fall-through), push accepted when full
// only if a pop happens in the same cycle; drop reports a rejected push.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  head,
  output logic        full,
  output logic        empty,
  output logic        drop,
  output logic [AW:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW + 1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign count   = count_reg;
  assign head    = empty ? 8'h00 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with combinational read, store steering,
// misalignment capture and the MMIO block (console FIFO, mtime, tohost).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Dmem_addr,
  input  logic [7:0]  Dmem_data_wr1,
  input  logic [7:0]  Dmem_data_wr2,
  input  logic [7:0]  Dmem_data_wr3,
  input  logic [7:0]  Dmem_data_wr4,
  input  logic [1:0]  Dmem_write_en,
  output logic [31:0] Dmem_data_read,
  output logic [7:0]  Tx_data,
  output logic        Tx_valid,
  input  logic        Tx_ready,
  output logic [31:0] Tohost,
  output logic        Tohost_valid,
  output logic        Misalign_err,
  output logic [31:0] Err_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    wr_byte [4];
  logic [7:0]    rd_lane [4];
  logic [31:0]   ram_word;
  logic [AW-1:0] word_idx;
  logic          ram_hit;
  logic          misaligned;
  logic          write_ok;

  logic [63:0]   mtime_reg;
  logic [31:0]   tohost_reg;
  logic          tohost_valid_reg;
  logic          misalign_err_reg;
  logic [31:0]   err_addr_reg;
  logic          overflow_reg;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;

  assign wr_byte[0] = Dmem_data_wr1;
  assign wr_byte[1] = Dmem_data_wr2;
  assign wr_byte[2] = Dmem_data_wr3;
  assign wr_byte[3] = Dmem_data_wr4;

  assign word_idx   = Dmem_addr[AW+1:2];
  assign ram_hit    = (Dmem_addr[31:AW+2] == '0);
  assign misaligned = is_misaligned(Dmem_write_en, Dmem_addr[1:0]);
  assign write_ok   = (Dmem_write_en != WE_NONE) && !misaligned;

  // One RAM per byte lane so each lane has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH_WORDS];
      logic       lane_we;
      logic [7:0] lane_data;

      always_comb begin
        lane_we   = 1'b0;
        lane_data = wr_byte[gi];
        case (Dmem_write_en)
          WE_BYTE: begin
            lane_we   = (Dmem_addr[1:0] == 2'(gi));
            lane_data = wr_byte[0];
          end
          WE_HALF: begin
            lane_we   = (Dmem_addr[1] == 1'(gi / 2));
            lane_data = wr_byte[gi % 2];
          end
          WE_WORD: lane_we = 1'b1;
          default: lane_we = 1'b0;
        endcase
      end

      always_ff @(posedge Clk) begin
        if (!Reset && write_ok && ram_hit && lane_we) begin
          ram[word_idx] <= lane_data;
        end
      end

      assign rd_lane[gi] = ram[word_idx];
    end
  endgenerate

  assign ram_word = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (write_ok && (Dmem_addr == UART_TX)),
    .push_data (Dmem_data_wr1),
    .pop       (Tx_ready),
    .head      (Tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .count     (fifo_count)
  );

  assign Tx_valid = !fifo_empty;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mtime_reg        <= '0;
      tohost_reg       <= '0;
      tohost_valid_reg <= 1'b0;
      misalign_err_reg <= 1'b0;
      err_addr_reg     <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      mtime_reg <= mtime_reg + 64'd1;
      if (fifo_drop) overflow_reg <= 1'b1;
      if (write_ok && (Dmem_write_en == WE_WORD) && (Dmem_addr == TOHOST)) begin
        tohost_reg       <= {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1};
        tohost_valid_reg <= 1'b1;
      end
      // Only the first offending address is kept for post-mortem.
      if (misaligned && !misalign_err_reg) begin
        misalign_err_reg <= 1'b1;
        err_addr_reg     <= Dmem_addr;
      end
    end
  end

  always_comb begin
    Dmem_data_read = '0;
    if (ram_hit) begin
      Dmem_data_read = ram_word;
    end else begin
      case (Dmem_addr)
        UART_STAT: Dmem_data_read = {16'h0, 8'(fifo_count), 5'h0, overflow_reg, fifo_empty, fifo_full};
        MTIME_LO:  Dmem_data_read = mtime_reg[31:0];
        MTIME_HI:  Dmem_data_read = mtime_reg[63:32];
        TOHOST:    Dmem_data_read = tohost_reg;
        default:   Dmem_data_read = '0;
      endcase
    end
  end

  assign Tohost       = tohost_reg;
  assign Tohost_valid = tohost_valid_reg;
  assign Misalign_err = misalign_err_reg;
  assign Err_addr     = err_addr_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array / queue reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DW = 4096;
  localparam int FD = 8;
  localparam int RB = DW * 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Dmem_addr;
  logic [7:0]  Dmem_data_wr1, Dmem_data_wr2, Dmem_data_wr3, Dmem_data_wr4;
  logic [1:0]  Dmem_write_en;
  logic [31:0] Dmem_data_read;
  logic [7:0]  Tx_data;
  logic        Tx_valid;
  logic        Tx_ready;
  logic [31:0] Tohost;
  logic        Tohost_valid;
  logic        Misalign_err;
  logic [31:0] Err_addr;

  dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk), .Reset(Reset), .Dmem_addr(Dmem_addr),
    .Dmem_data_wr1(Dmem_data_wr1), .Dmem_data_wr2(Dmem_data_wr2),
    .Dmem_data_wr3(Dmem_data_wr3), .Dmem_data_wr4(Dmem_data_wr4),
    .Dmem_write_en(Dmem_write_en), .Dmem_data_read(Dmem_data_read),
    .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready),
    .Tohost(Tohost), .Tohost_valid(Tohost_valid),
    .Misalign_err(Misalign_err), .Err_addr(Err_addr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  mem_m [RB];
  bit          known [RB];
  logic [7:0]  q [$];
  bit          ovf_m, tv_m, err_m;
  logic [63:0] mtime_m;
  logic [31:0] tohost_m, err_addr_m;
  logic [31:0] rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_mask(input logic [31:0] a);
    logic [31:0] m = 32'hFFFF_FFFF;
    if (a < RB) begin
      for (int i = 0; i < 4; i++)
        if (!known[int'({a[31:2], 2'b00}) + i]) m[8*i +: 8] = 8'h00;
    end
    return m;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r = '0;
    if (a < RB) begin
      for (int i = 0; i < 4; i++)
        if (known[int'({a[31:2], 2'b00}) + i]) r[8*i +: 8] = mem_m[int'({a[31:2], 2'b00}) + i];
    end else if (a == UART_STAT) begin
      r = {16'h0, 8'(q.size()), 5'h0, ovf_m, (q.size() == 0), (q.size() == FD)};
    end else if (a == MTIME_LO) begin
      r = mtime_m[31:0];
    end else if (a == MTIME_HI) begin
      r = mtime_m[63:32];
    end else if (a == TOHOST) begin
      r = tohost_m;
    end
    return r;
  endfunction

  task automatic compare_all();
    logic [31:0] m;
    m = read_mask(Dmem_addr);
    check("read_data", Dmem_data_read & m, model_read(Dmem_addr) & m);
    check("tx_valid", 32'(Tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("tx_data", 32'(Tx_data), 32'(q[0]));
    check("tohost", Tohost, tohost_m);
    check("tohost_valid", 32'(Tohost_valid), 32'(tv_m));
    check("misalign_err", 32'(Misalign_err), 32'(err_m));
    check("err_addr", Err_addr, err_addr_m);
  endtask

  task automatic put_byte(input int a, input logic [7:0] b);
    mem_m[a] = b;
    known[a] = 1'b1;
  endtask

  task automatic model_update();
    logic [31:0] a;
    bit pop, mis, wr;
    a   = Dmem_addr;
    pop = (q.size() != 0) && Tx_ready;
    if (Reset) begin
      q.delete();
      ovf_m = 0; tv_m = 0; err_m = 0;
      mtime_m = '0; tohost_m = '0; err_addr_m = '0;
      return;
    end
    mis = ((Dmem_write_en == WE_HALF) && (a % 2 != 0)) || ((Dmem_write_en == WE_WORD) && (a % 4 != 0));
    if (mis && !err_m) begin
      err_m = 1;
      err_addr_m = a;
    end
    wr = (Dmem_write_en != WE_NONE) && !mis;
    if (wr && a < RB) begin
      case (Dmem_write_en)
        WE_BYTE: put_byte(int'(a), Dmem_data_wr1);
        WE_HALF: begin put_byte(int'(a), Dmem_data_wr1); put_byte(int'(a) + 1, Dmem_data_wr2); end
        default: begin
          put_byte(int'(a), Dmem_data_wr1);     put_byte(int'(a) + 1, Dmem_data_wr2);
          put_byte(int'(a) + 2, Dmem_data_wr3); put_byte(int'(a) + 3, Dmem_data_wr4);
        end
      endcase
    end
    if (pop) void'(q.pop_front());
    if (wr && a == UART_TX) begin
      if (q.size() < FD) q.push_back(Dmem_data_wr1);
      else ovf_m = 1;
    end
    if (wr && Dmem_write_en == WE_WORD && a == TOHOST) begin
      tohost_m = {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1};
      tv_m = 1;
    end
    mtime_m = mtime_m + 64'd1;
  endtask

  // One bus cycle: drive at negedge, compare settled outputs, advance the model.
  task automatic cyc(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d,
                     input logic ready, input logic rst);
    @(negedge Clk);
    Reset = rst;
    Dmem_addr = a;
    Dmem_write_en = w;
    {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = d;
    Tx_ready = ready;
    #1;
    rdata = Dmem_data_read;
    compare_all();
    model_update();
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    int ready_bias;

    for (int i = 0; i < RB; i++) known[i] = 1'b0;
    Reset = 1'b1; Dmem_addr = '0; Dmem_write_en = WE_NONE; Tx_ready = 1'b0;
    {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = '0;
    repeat (2) @(posedge Clk);
    model_update();

    // Reset state
    cyc(UART_STAT, WE_NONE, 0, 0, 0);
    check("rst_stat", rdata, 32'h0000_0002);
    check("rst_tx_valid", 32'(Tx_valid), 32'h0);
    check("rst_tx_data", 32'(Tx_data), 32'h0);

    // Lane steering
    cyc(32'h10, WE_WORD, 32'hDEADBEEF, 0, 0);
    cyc(32'h12, WE_BYTE, 32'h0000_0055, 0, 0);
    cyc(32'h10, WE_NONE, 0, 0, 0);
    check("byte_store", rdata, 32'hDE55BEEF);
    cyc(32'h10, WE_HALF, 32'h0000_1234, 0, 0);
    check("read_old_in_write_cycle", rdata, 32'hDE55BEEF);
    cyc(32'h10, WE_NONE, 0, 0, 0);
    check("half_store", rdata, 32'hDE551234);

    // Misalignment
    cyc(32'h20, WE_WORD, 32'h11223344, 0, 0);
    cyc(32'h22, WE_WORD, 32'hAAAAAAAA, 0, 0);
    cyc(32'h20, WE_NONE, 0, 0, 0);
    check("misaligned_suppressed", rdata, 32'h11223344);
    check("misalign_err_set", 32'(Misalign_err), 32'h1);
    check("err_addr_first", Err_addr, 32'h22);
    cyc(32'h31, WE_HALF, 32'hBBBB, 0, 0);
    cyc(32'h30, WE_NONE, 0, 0, 0);
    check("err_addr_kept", Err_addr, 32'h22);

    // FIFO overflow then drain
    cyc(0, WE_NONE, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(UART_TX, WE_BYTE, 32'h41 + i, 0, 0);
    cyc(UART_STAT, WE_NONE, 0, 0, 0);
    check("stat_full_ovf", rdata, 32'h0000_0805);
    for (int i = 0; i < 8; i++) begin
      cyc(0, WE_NONE, 0, 1, 0);
      check("drain_byte", 32'(Tx_data), 32'h41 + i);
    end
    cyc(0, WE_NONE, 0, 1, 0);
    check("drain_done", 32'(Tx_valid), 32'h0);

    // Push into a full FIFO while popping
    cyc(0, WE_NONE, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(UART_TX, WE_BYTE, 32'h41 + i, 0, 0);
    cyc(UART_TX, WE_WORD, 32'h5A, 1, 0);
    cyc(UART_STAT, WE_NONE, 0, 0, 0);
    check("stat_full_no_ovf", rdata, 32'h0000_0801);
    for (int i = 0; i < 8; i++) cyc(0, WE_NONE, 0, 1, 0);
    check("last_is_Z", 32'(Tx_data), 32'h5A);

    // MTIME
    cyc(0, WE_NONE, 0, 0, 1);
    repeat (10) cyc(0, WE_NONE, 0, 0, 0);
    cyc(MTIME_LO, WE_NONE, 0, 0, 0);
    check("mtime_10", rdata, 32'd10);
    @(posedge Clk);
    #1 force dut.mtime_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.mtime_reg;
    mtime_m = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(MTIME_LO, WE_NONE, 0, 0, 0);
    check("mtime_max_lo", rdata, 32'hFFFF_FFFF);
    cyc(MTIME_HI, WE_NONE, 0, 0, 0);
    check("mtime_wrap_hi", rdata, 32'h0);
    cyc(MTIME_LO, WE_NONE, 0, 0, 0);
    check("mtime_after_wrap_lo", rdata, 32'h1);

    // TOHOST, MMIO misalignment, reset during drain
    cyc(TOHOST, WE_WORD, 32'h1, 0, 0);
    cyc(TOHOST, WE_NONE, 0, 0, 0);
    check("tohost_value", Tohost, 32'h1);
    check("tohost_valid", 32'(Tohost_valid), 32'h1);
    check("tohost_read", rdata, 32'h1);
    cyc(32'h8000_0003, WE_HALF, 32'hFFFF, 0, 0);
    cyc(0, WE_NONE, 0, 0, 0);
    check("mmio_misalign_addr", Err_addr, 32'h8000_0003);
    for (int i = 0; i < 3; i++) cyc(UART_TX, WE_BYTE, 32'h61 + i, 0, 0);
    cyc(0, WE_NONE, 0, 1, 0);
    cyc(UART_TX, WE_BYTE, 32'h7A, 1, 1);
    cyc(32'h10, WE_NONE, 0, 1, 0);
    check("rst_drain_valid", 32'(Tx_valid), 32'h0);
    check("rst_drain_data", 32'(Tx_data), 32'h0);
    check("rst_tohost", Tohost, 32'h0);
    check("rst_tohost_valid", 32'(Tohost_valid), 32'h0);
    check("rst_misalign", 32'(Misalign_err), 32'h0);
    check("rst_err_addr", Err_addr, 32'h0);
    check("ram_retained", rdata, 32'hDE551234);

    // Random traffic
    ready_bias = 2;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) ready_bias = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = $urandom_range(0, 63);
        5:             a = 32'h3FF0 + $urandom_range(0, 31);
        6, 7, 8:       a = ($urandom_range(0, 1) == 0) ? UART_TX : 32'h8000_0000 + $urandom_range(0, 23);
        default:       a = $urandom;
      endcase
      w = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) begin
        if (w == WE_WORD) a[1:0] = 2'b00;
        if (w == WE_HALF) a[0] = 1'b0;
      end
      cyc(a, w, $urandom, ($urandom_range(0, 3) < ready_bias), ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port.
- Accepts the core's address, four write byte lanes and 2-bit store-size code. Returns read data combinationally, so the core's single-cycle memory timing holds.
- Contains the data RAM, byte-lane write steering, misalignment checking, and a small MMIO region: console TX FIFO with valid/ready drain, 64-bit cycle counter, and tohost register for simulation exit.
- Sits beside top_core in the simulation/FPGA top; replaces the external C++ data-memory model.

Parameters:
- DEPTH_WORDS, 4096, RAM depth in 32-bit words (power of 2); RAM occupies bytes 0 .. DEPTH_WORDS*4-1.
- FIFO_DEPTH, 8, console TX FIFO entries (power of 2, >= 2).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Dmem_addr  in  32  byte address from the core.
- Dmem_data_wr1  in  8  store byte 0 (least significant byte of store data).
- Dmem_data_wr2  in  8  store byte 1.
- Dmem_data_wr3  in  8  store byte 2.
- Dmem_data_wr4  in  8  store byte 3.
- Dmem_write_en  in  2  store size: 00 none, 01 byte, 10 half, 11 word.
- Dmem_data_read  out  32  word at Dmem_addr with bits [1:0] ignored (combinational).
- Tx_data  out  8  FIFO head byte.
- Tx_valid  out  1  FIFO not empty.
- Tx_ready  in  1  sink accepts the head byte this cycle.
- Tohost  out  32  last value written to tohost.
- Tohost_valid  out  1  sticky flag, set on the first tohost write.
- Misalign_err  out  1  sticky misaligned-store flag.
- Err_addr  out  32  address of the first misaligned store.

Behaviour:
- Address map, with match on the full 32-bit address:
  - RAM: addr < DEPTH_WORDS*4. Word index is addr[log2(DEPTH_WORDS)+1:2].
  - 0x8000_0000 UART_TX (write only; reads return 0).
  - 0x8000_0004 UART_STAT (read): bit0 full, bit1 empty, bit2 overflow, bits[15:8] count.
  - 0x8000_0008 MTIME_LO and 0x8000_000C MTIME_HI (read only).
  - 0x8000_0010 TOHOST (read/write).
  - Unmapped addresses: reads return 0, writes are ignored.
- Reads: purely combinational and side-effect free. In the cycle a write occurs, the read returns the old value; the new value is visible in the next cycle.
- Store lane steering (RAM only):
  - Byte: wr1 goes to byte lane addr[1:0].
  - Half: wr1/wr2 go to lanes {addr[1],0} and {addr[1],1}.
  - Word: wr1..wr4 go to lanes 0..3.
  - All other lanes are unchanged.
- Misalignment:
  - Half store with addr[0]=1, or word store with addr[1:0]!=0: the write is suppressed.
  - On the first occurrence, Misalign_err is set and Err_addr captures the address; later misaligned stores do not overwrite Err_addr.
  - Applies to MMIO addresses as well.
- UART_TX write (any size): pushes byte wr1.
  - If the FIFO is full and Tx_ready=0 that cycle, the byte is dropped and the sticky overflow bit is set.
  - If full with a pop in the same cycle, the push is accepted and count is unchanged.
- FIFO:
  - No fall-through: a push into an empty FIFO raises Tx_valid on the next cycle.
  - A pop occurs when Tx_valid && Tx_ready.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- MTIME: 64-bit counter, increments every cycle after reset, wraps at 2^64-1 to 0. Reading LO then HI may tear; software retries.
- TOHOST write (word only): updates Tohost and sets Tohost_valid. A later write updates the value and the flag stays 1.
- Reset:
  - Has priority over any concurrent write or push.
  - Next-cycle values: FIFO empty, overflow 0, Tx_valid 0, Tx_data 0, MTIME 0, Tohost 0, Tohost_valid 0, Misalign_err 0, Err_addr 0.
  - RAM contents are not cleared.
  - A pop pending during reset is discarded.

Decomposition:
- Shared package holds:
  - address-map constants: UART_TX, UART_STAT, MTIME_LO, MTIME_HI, TOHOST;
  - store-size encodings: WE_NONE, WE_BYTE, WE_HALF, WE_WORD.
- top_core's stages use the same store-size encodings.
- One sub-module: tx_fifo (synchronous FIFO with push, pop, full, empty, count).
- Address decode, lane steering and RAM stay in dmem_responder.

Test Plan:
1. Word store 0xDEADBEEF at 0x10, then byte store 0x55 at 0x12 -> read 0x10 returns 0xDE55BEEF; half store 0x1234 at 0x10 -> 0xDE551234.
2. Word store at 0x22 -> RAM at 0x20 unchanged, Misalign_err=1, Err_addr=0x22. A second misaligned store at 0x31 -> Err_addr stays 0x22.
3. With Tx_ready=0, push 'A'..'I' (9 bytes) into FIFO_DEPTH=8 -> count=8, overflow=1, 'I' dropped. Then set Tx_ready=1 -> Tx_data reads 'A'..'H' on consecutive cycles, then Tx_valid=0.
4. FIFO full, push 'Z' with Tx_ready=1 in the same cycle -> 'Z' accepted, count stays 8, overflow unchanged.
5. Read MTIME_LO 10 cycles after reset release -> 10 (±1 per the counter's defined start). Force the counter to 0xFFFFFFFF_FFFFFFFF -> next cycle LO=0, HI=0.
6. Word write 0x00000001 to TOHOST -> Tohost=1 and Tohost_valid=1 next cycle. Assert Reset during a TX drain -> all outputs return to their reset values in one cycle, and RAM data is retained.
